// File: rtl/pll_drp_pkg.sv
// Shared types and helpers for the PLLE2 DRP reconfiguration controller.
package pll_drp_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RST, S_RD1, S_WRD1, S_WR1, S_WWR1,
    S_RD2, S_WRD2, S_WR2, S_WWR2, S_REL, S_WLOCK, S_ARST
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK = 2'd0, ERR_ARG = 2'd1, ERR_DRDY = 2'd2, ERR_LOCK = 2'd3
  } err_t;

  localparam logic [15:0] KEEP1   = 16'hF000;
  localparam logic [15:0] KEEP2   = 16'hFF3F;
  localparam int          DIV_MAX = 128;

  // First register of each output's pair; the second is always at +1.
  function automatic logic [6:0] reg1_addr(input logic [2:0] sel);
    case (sel)
      3'd0:    return 7'h08;
      3'd1:    return 7'h0A;
      3'd2:    return 7'h0C;
      3'd3:    return 7'h0E;
      3'd4:    return 7'h10;
      3'd5:    return 7'h06;
      default: return 7'h00;
    endcase
  endfunction

  // 6-bit fields wrap for d==128, giving the PLLE2 high=low=0 encoding.
  function automatic logic [15:0] reg1_data(input logic [15:0] rd, input logic [7:0] d);
    logic [5:0] hi, lo;
    hi = (d == 8'd1) ? 6'd1 : d[6:1];
    lo = (d == 8'd1) ? 6'd1 : 6'(d - {1'b0, d[7:1]});
    return (rd & KEEP1) | {4'd0, hi, lo};
  endfunction

  // Divide-by-1 bypasses the counter, so edge is forced low there.
  function automatic logic [15:0] reg2_data(input logic [15:0] rd, input logic [7:0] d);
    logic edg, nc;
    nc  = (d == 8'd1);
    edg = d[0] && !nc;
    return (rd & KEEP2) | {8'd0, edg, nc, 6'd0};
  endfunction

endpackage

// File: rtl/pll_drp_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module pll_drp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) {q, meta} <= 2'b00;
    else     {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/red_pitaya_pll_drp.sv
// PLLE2 runtime divider reconfiguration over DRP: reset PLL, two RMWs, relock.
// Define PLL_DRP_LOCKMON_EN to add lock-loss counting and automatic relock.
module red_pitaya_pll_drp
  import pll_drp_pkg::*;
#(
  parameter int N_OUT   = 6,
  parameter int DIV_W   = 8,
  parameter int LOCK_TO = 65536,
  parameter int DRDY_TO = 64
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [6:0]       drp_daddr,
  output logic             drp_den,
  output logic             drp_dwe,
  output logic [15:0]      drp_di,
  input  logic [15:0]      drp_do,
  input  logic             drp_drdy,
  output logic             pll_rst,
  input  logic             pll_locked,
  output logic             locked
`ifdef PLL_DRP_LOCKMON_EN
  ,
  output logic [15:0]      lock_loss_cnt
`endif
);

  localparam int TW = $clog2(LOCK_TO + DRDY_TO + 16);
  localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TO - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TO - 1);
  localparam logic [TW-1:0] ARST_LAST = TW'(15);

  state_t           state, state_nxt;
  err_t             fin_code;
  logic [2:0]       sel_q;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      wdat;
  logic [TW-1:0]    tmr;
  logic [6:0]       a1;
  logic             boot, auto_q, accept, bad, drdy_exp, lock_exp, relock, fin;

  assign accept   = cfg_valid && cfg_ready;
  assign bad      = (32'(sel_q) >= N_OUT) || (div_q == '0) || (32'(div_q) > DIV_MAX);
  assign drdy_exp = (tmr == DRDY_LAST);
  assign lock_exp = (tmr == LOCK_LAST);
  assign a1       = reg1_addr(sel_q);

  pll_drp_sync u_sync (.clk(clk), .rst(rst), .d(pll_locked), .q(locked));

`ifdef PLL_DRP_LOCKMON_EN
  logic locked_q;
  // A drop while pll_rst is held (e.g. after a drdy timeout) is expected, not a loss.
  assign relock = (state == S_IDLE) && !pll_rst && locked_q && !locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q      <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      locked_q <= locked;
      if (relock && lock_loss_cnt != 16'hFFFF) lock_loss_cnt <= lock_loss_cnt + 16'd1;
    end
  end
`else
  assign relock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CHECK;
               else if (relock) state_nxt = S_ARST;
      S_CHECK: state_nxt = bad ? S_IDLE : S_RST;
      S_RST:   state_nxt = S_RD1;
      S_RD1:   state_nxt = S_WRD1;
      S_WRD1:  if (drp_drdy) state_nxt = S_WR1;  else if (drdy_exp) state_nxt = S_IDLE;
      S_WR1:   state_nxt = S_WWR1;
      S_WWR1:  if (drp_drdy) state_nxt = S_RD2;  else if (drdy_exp) state_nxt = S_IDLE;
      S_RD2:   state_nxt = S_WRD2;
      S_WRD2:  if (drp_drdy) state_nxt = S_WR2;  else if (drdy_exp) state_nxt = S_IDLE;
      S_WR2:   state_nxt = S_WWR2;
      S_WWR2:  if (drp_drdy) state_nxt = S_REL;  else if (drdy_exp) state_nxt = S_IDLE;
      S_REL:   state_nxt = S_WLOCK;
      S_WLOCK: if (locked || lock_exp) state_nxt = S_IDLE;
      S_ARST:  if (tmr == ARST_LAST) state_nxt = S_REL;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    drp_daddr = '0;
    drp_di    = '0;
    fin       = 1'b0;
    fin_code  = ERR_OK;
    case (state)
      S_CHECK: if (bad) begin fin = 1'b1; fin_code = ERR_ARG; end
      S_RD1:   begin drp_den = 1'b1; drp_daddr = a1; end
      S_WR1:   begin drp_den = 1'b1; drp_dwe = 1'b1; drp_daddr = a1; drp_di = wdat; end
      S_RD2:   begin drp_den = 1'b1; drp_daddr = 7'(a1 + 7'd1); end
      S_WR2:   begin drp_den = 1'b1; drp_dwe = 1'b1; drp_daddr = 7'(a1 + 7'd1); drp_di = wdat; end
      S_WRD1, S_WWR1, S_WRD2, S_WWR2:
        if (!drp_drdy && drdy_exp) begin fin = 1'b1; fin_code = ERR_DRDY; end
      // Automatic relock completes silently.
      S_WLOCK:
        if (locked)        begin fin = !auto_q; fin_code = ERR_OK;   end
        else if (lock_exp) begin fin = !auto_q; fin_code = ERR_LOCK; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr       <= '0;
      boot      <= 1'b1;
      auto_q    <= 1'b0;
      sel_q     <= '0;
      div_q     <= '0;
      wdat      <= '0;
      cfg_ready <= 1'b0;
      done      <= 1'b0;
      err_code  <= ERR_OK;
      pll_rst   <= 1'b1;
    end else begin
      tmr       <= (state_nxt != state || state == S_IDLE) ? '0 : tmr + TW'(1);
      boot      <= 1'b0;
      cfg_ready <= (state_nxt == S_IDLE);
      done      <= fin;
      if (fin)         err_code <= fin_code;
      else if (accept) err_code <= ERR_OK;
      if (accept) begin
        sel_q <= cfg_sel;
        div_q <= cfg_div;
      end
      if (state_nxt == S_ARST)       auto_q <= 1'b1;
      else if (state_nxt == S_CHECK) auto_q <= 1'b0;
      if (drp_drdy && state == S_WRD1) wdat <= reg1_data(drp_do, 8'(div_q));
      if (drp_drdy && state == S_WRD2) wdat <= reg2_data(drp_do, 8'(div_q));
      // pll_rst stays high after a drdy timeout; only boot or a completed write sequence clears it.
      if (boot)                                              pll_rst <= 1'b0;
      else if (state_nxt == S_RST || state_nxt == S_ARST)    pll_rst <= 1'b1;
      else if (state_nxt == S_REL)                           pll_rst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_red_pitaya_pll_drp.sv
// Directed + randomized bench for red_pitaya_pll_drp with DRP slave and PLL lock models.
module tb_red_pitaya_pll_drp;
  localparam int N_OUT = 6, DIV_W = 8, LOCK_TO = 300, DRDY_TO = 16;

  logic             clk = 0, rst = 1, cfg_valid = 0, cfg_ready, done;
  logic [2:0]       cfg_sel = 0;
  logic [DIV_W-1:0] cfg_div = 0;
  logic [1:0]       err_code;
  logic [6:0]       drp_daddr;
  logic             drp_den, drp_dwe, drp_drdy = 0, pll_rst, pll_locked = 0, locked;
  logic [15:0]      drp_di, drp_do;
`ifdef PLL_DRP_LOCKMON_EN
  logic [15:0]      lock_loss_cnt;
`endif

  red_pitaya_pll_drp #(.N_OUT(N_OUT), .DIV_W(DIV_W), .LOCK_TO(LOCK_TO), .DRDY_TO(DRDY_TO)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_div(cfg_div), .done(done), .err_code(err_code), .drp_daddr(drp_daddr),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do),
    .drp_drdy(drp_drdy), .pll_rst(pll_rst), .pll_locked(pll_locked), .locked(locked)
`ifdef PLL_DRP_LOCKMON_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #4 clk = ~clk;

  typedef struct { logic [6:0] a; logic we; logic [15:0] d; } txn_t;
  txn_t log_q[$];
  localparam logic [6:0] ADDR_TBL [6] = '{7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h10, 7'h06};

  int cyc = 0, n_cmp = 0, n_bad = 0, cd = 0, lcnt = 0, last_drdy_cyc = -1;
  int lat_min = 1, lat_max = 3, lock_dly = 20;
  bit drdy_en = 1, lock_block = 0, drop = 0;
  logic [15:0] rd_val = 0;
  assign drp_do = rd_val;

  // DRP slave and PLL behaviour, updated just after each rising edge.
  initial forever begin
    @(posedge clk); cyc++; #1;
    drp_drdy = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin drp_drdy = 1; last_drdy_cyc = cyc; end
    end
    if (drp_den) begin
      txn_t t;
      t.a = drp_daddr; t.we = drp_dwe; t.d = drp_di;
      log_q.push_back(t);
      if (drdy_en) cd = $urandom_range(lat_max, lat_min);
    end
    if (pll_rst || drop) begin pll_locked = 0; lcnt = 0; end
    else if (!lock_block) begin
      if (lcnt >= lock_dly) pll_locked = 1; else lcnt++;
    end
  end

  function automatic logic [15:0] ref_w1(input logic [15:0] rd, input int d);
    int hi, lo;
    if (d == 1) begin hi = 1; lo = 1; end
    else begin hi = (d / 2) % 64; lo = (d - d / 2) % 64; end
    return (rd & 16'hF000) | 16'(hi * 64 + lo);
  endfunction

  function automatic logic [15:0] ref_w2(input logic [15:0] rd, input int d);
    int e, nc;
    nc = (d == 1) ? 1 : 0;
    e  = (d == 1) ? 0 : d % 2;
    return (rd & 16'hFF3F) | 16'(e * 128 + nc * 64);
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_locked();
    int n = 0;
    while (!(locked && cfg_ready) && n < 500) begin tick(); n++; end
    chk("locked_idle", {locked, cfg_ready}, 2'b11);
  endtask

  task automatic send(input logic [2:0] s, input int d, output int t_acc);
    int n = 0;
    while (!cfg_ready && n < 1000) begin tick(); n++; end
    cfg_sel = s; cfg_div = DIV_W'(d); cfg_valid = 1; t_acc = cyc;
    tick();
    cfg_valid = 0;
  endtask

  task automatic run_ok(input logic [2:0] s, input int d, input logic [15:0] rd);
    int t, n, t_fall;
    txn_t e;
    rd_val = rd; log_q.delete();
    send(s, d, t);
    tick();
    chk("pll_rst_T2", {pll_rst, done}, 2'b10);
    tick();
    chk("den_T3", {drp_den, drp_dwe, drp_daddr}, {2'b10, ADDR_TBL[s]});
    t_fall = -1; n = 0;
    while (!done && n < LOCK_TO + 500) begin
      tick(); n++;
      if (!pll_rst && t_fall < 0) t_fall = cyc;
    end
    chk("done_ok", {done, err_code, cfg_ready, locked}, 5'b1_00_1_1);
    chk("rst_release", t_fall, last_drdy_cyc + 1);
    chk("n_txn", log_q.size(), 4);
    if (log_q.size() == 4) begin
      e = log_q[0]; chk("rd1", {e.we, e.a}, {1'b0, ADDR_TBL[s]});
      e = log_q[1]; chk("wr1", {e.we, e.a, e.d}, {1'b1, ADDR_TBL[s], ref_w1(rd, d)});
      e = log_q[2]; chk("rd2", {e.we, e.a}, {1'b0, 7'(ADDR_TBL[s] + 7'd1)});
      e = log_q[3]; chk("wr2", {e.we, e.a, e.d}, {1'b1, 7'(ADDR_TBL[s] + 7'd1), ref_w2(rd, d)});
    end
    tick();
    chk("done_pulse", done, 0);
  endtask

  task automatic run_bad(input logic [2:0] s, input int d);
    int t;
    logic prst;
    log_q.delete(); prst = pll_rst;
    send(s, d, t);
    chk("bad_T1", done, 0);
    tick();
    chk("bad_T2", {done, err_code, pll_rst}, {1'b1, 2'd1, prst});
    chk("bad_T2_cyc", cyc - t, 2);
    repeat (3) tick();
    chk("bad_no_den", log_q.size(), 0);
  endtask

  initial begin
    int t, n, rcnt, dcnt;
    bit saw_low, saw_done;
    rst = 1;
    repeat (3) tick();
    chk("rst_vals", {cfg_ready, done, err_code, drp_den, drp_dwe, drp_daddr, drp_di, pll_rst, locked},
        {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0});
`ifdef PLL_DRP_LOCKMON_EN
    chk("rst_llc", lock_loss_cnt, 0);
`endif
    rst = 0;
    tick();
    chk("first_cycle", {pll_rst, cfg_ready}, 2'b01);
    wait_locked();

    lock_dly = 100; run_ok(3'd2, 8, 16'hFFFF); lock_dly = 20;
    wait_locked(); run_ok(3'd5, 5, 16'h0000);
    wait_locked(); run_ok(3'd0, 1, 16'h0000);
    wait_locked(); run_ok(3'd3, 128, 16'h1234);
    run_bad(3'd0, 0);
    run_bad(3'd6, 8);
    run_bad(3'd1, 129);

    lat_max = 5;
    for (int i = 0; i < 8; i++) begin
      wait_locked();
      run_ok(3'($urandom_range(5, 0)), int'($urandom_range(128, 1)), 16'($urandom));
    end
    lat_max = 3;

    // DRP slave never answers.
    wait_locked();
    drdy_en = 0; log_q.delete();
    send(3'd1, 10, t);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("drdy_to", {done, err_code, pll_rst}, {1'b1, 2'd2, 1'b1});
    chk("drdy_to_cyc", cyc - t, DRDY_TO + 4);
    chk("drdy_to_txn", log_q.size(), 1);
    drdy_en = 1;

    // PLL never locks.
    lock_block = 1;
    send(3'd3, 20, t);
    n = 0;
    while (!done && n < LOCK_TO + 200) begin tick(); n++; end
    chk("lock_to", {done, err_code, locked, pll_rst}, {1'b1, 2'd3, 1'b0, 1'b0});
    lock_block = 0;
    wait_locked();

    // Reset during the first write's drdy wait.
    lat_min = 10; lat_max = 10;
    send(3'd4, 16, t);
    n = 0;
    while (!(drp_den && drp_dwe) && n < 100) begin tick(); n++; end
    tick();
    rst = 1;
    tick();
    chk("midrst_vals", {cfg_ready, done, err_code, drp_den, drp_dwe, drp_daddr, drp_di, pll_rst, locked},
        {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0});
    rst = 0;
    tick();
    chk("midrst_release", {pll_rst, cfg_ready}, 2'b01);
    saw_done = 0;
    repeat (15) begin tick(); if (done || drp_den) saw_done = 1; end
    chk("stray_drdy_ignored", saw_done, 0);
    lat_min = 1; lat_max = 3;
    wait_locked();
    run_ok(3'd4, 16, 16'hA5A5);

`ifdef PLL_DRP_LOCKMON_EN
    wait_locked();
    drop = 1; tick(); drop = 0;
    rcnt = 0; dcnt = 0; saw_low = 0;
    repeat (200) begin
      tick();
      if (pll_rst) rcnt++;
      if (done) dcnt++;
      if (!cfg_ready) saw_low = 1;
    end
    chk("llc", lock_loss_cnt, 1);
    chk("relock_rst_len", rcnt, 16);
    chk("relock_quiet", {dcnt[7:0], saw_low, cfg_ready, locked}, {8'd0, 3'b111});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
